// File: rtl/truth_table_sequencer_if.sv
// truth_table_sequencer_if
//
// Purpose: groups every non-clock signal of the truth-table sequencer into
// one bundle. This covers the scan request and status, the breadboard drive
// and response, the captured-row stream and the table read port.
//
// Signals:
//   start      scan request (controller -> sequencer)
//   busy       scan in progress
//   w,x,y,z    breadboard inputs, {w,x,y,z} = current code, w is the MSB
//   r[9:0]     breadboard response
//   row_valid  one-cycle pulse per captured row
//   row_idx    code of the captured row
//   row_data   captured response
//   done       one-cycle pulse together with the row-15 row_valid
//   ones_count set bits accumulated over the current/last scan
//   rd_addr    table read address
//   rd_data    registered table read data
//
// Modports:
//   slave  - the sequencer itself
//   master - the controller/breadboard side that requests scans and answers
interface truth_table_sequencer_if;

    logic       start;
    logic       busy;
    logic       w;
    logic       x;
    logic       y;
    logic       z;
    logic [9:0] r;
    logic       row_valid;
    logic [3:0] row_idx;
    logic [9:0] row_data;
    logic       done;
    logic [7:0] ones_count;
    logic [3:0] rd_addr;
    logic [9:0] rd_data;

    // The sequencer accepts requests, the breadboard response and read
    // addresses, and drives everything else.
    modport slave (
        input  start,
        input  r,
        input  rd_addr,
        output w,
        output x,
        output y,
        output z,
        output busy,
        output row_valid,
        output row_idx,
        output row_data,
        output done,
        output ones_count,
        output rd_data
    );

    // The controller/breadboard side is the mirror image of the sequencer.
    modport master (
        output start,
        output r,
        output rd_addr,
        input  w,
        input  x,
        input  y,
        input  z,
        input  busy,
        input  row_valid,
        input  row_idx,
        input  row_data,
        input  done,
        input  ones_count,
        input  rd_data
    );

endinterface

// File: rtl/truth_table_sequencer.sv
// truth_table_sequencer
//
// Purpose: cycle-exact scan of the 4-input/10-output breadboard logic. On a
// start request it steps {w,x,y,z} through codes 0..15. For each code it
// waits SETTLE cycles and then spends one capture cycle. At the end of that
// cycle it stores r[9:0] in a 16-entry table, streams the row out and adds
// its set bits to ones_count. The table stays readable through a registered
// read port.
//
// Parameters:
//   SETTLE     wait cycles per code before sampling, legal range 1..255
//
// Ports:
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset (deassertion synchronised outside)
//   bus        truth_table_sequencer_if.slave, carries start/busy/done,
//              w,x,y,z/r, the row stream, ones_count and the read port
module truth_table_sequencer #(
    parameter int SETTLE = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    truth_table_sequencer_if.slave bus
);

    // A zero settle time would give no wait cycle at all, and the counter is
    // only 8 bits wide, so anything outside 1..255 is rejected when built.
    generate
        if (SETTLE < 1 || SETTLE > 255) begin : g_bad_settle
            $error("truth_table_sequencer: SETTLE must be in 1..255, got %0d", SETTLE);
        end
    endgenerate

    // The counter is reloaded with SETTLE-1 and runs down to zero. Counting
    // the zero cycle, that gives exactly SETTLE cycles in WAIT.
    localparam logic [7:0] SETTLE_RELOAD = 8'(SETTLE - 1);
    localparam logic [3:0] LAST_IDX      = 4'd15;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t     state;
    state_t     next_state;

    logic [3:0] idx;
    logic [7:0] cnt;

    logic       busy_q;
    logic       done_q;
    logic [7:0] ones_q;
    logic       row_valid_q;
    logic [3:0] row_idx_q;
    logic [9:0] row_data_q;
    logic [9:0] rd_data_q;
    logic [9:0] mem [16];

    logic       accept_start;
    logic       count_down;
    logic       capture_row;
    logic       last_row;
    logic [3:0] row_ones;

    // Number of set bits in a 10-bit response (0..10).
    function automatic logic [3:0] popcount10(input logic [9:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 10; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    assign last_row = (idx == LAST_IDX);
    assign row_ones = popcount10(bus.r);

    // State register. Reset can arrive at any point in a scan and always
    // abandons it, so a scan cut short by reset never reaches done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. start is looked at only in IDLE, so holding it high
    // during a scan neither restarts nor queues another scan. The cycle that
    // shows done is already IDLE, so back-to-back scans need no gap.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (cnt == 8'd0) begin
                    next_state = CAPTURE;
                end
            end
            CAPTURE: begin
                next_state = last_row ? IDLE : WAIT;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Output decode. These turn the current state into single-purpose
    // strobes, and the datapath blocks below act only on the strobes.
    always_comb begin
        accept_start = 1'b0;
        count_down   = 1'b0;
        capture_row  = 1'b0;
        case (state)
            IDLE:    accept_start = bus.start;
            WAIT:    count_down   = (cnt != 8'd0);
            CAPTURE: capture_row  = 1'b1;
            default: begin
                accept_start = 1'b0;
            end
        endcase
    end

    // Code and settle counter. idx drives the breadboard directly, so the
    // inputs move only when a scan starts or a non-final capture ends. After
    // the last row idx stays at 15, and the breadboard keeps that code until
    // the next scan.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= 4'd0;
            cnt <= 8'd0;
        end else if (accept_start) begin
            idx <= 4'd0;
            cnt <= SETTLE_RELOAD;
        end else if (count_down) begin
            cnt <= cnt - 8'd1;
        end else if (capture_row && !last_row) begin
            idx <= idx + 4'd1;
            cnt <= SETTLE_RELOAD;
        end
    end

    // Scan status. busy covers the whole scan. done pulses for exactly one
    // cycle, in step with the row-15 row_valid, on the same edge where busy
    // drops. ones_count restarts at each accepted start and otherwise keeps
    // the total of the last scan. 16 rows of at most 10 bits is 160, which
    // fits in 8 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            ones_q <= 8'd0;
        end else begin
            done_q <= 1'b0;
            if (accept_start) begin
                busy_q <= 1'b1;
                ones_q <= 8'd0;
            end else if (capture_row) begin
                ones_q <= ones_q + {4'b0000, row_ones};
                if (last_row) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    // Row stream. Each capture edge produces one row_valid pulse. row_idx
    // and row_data hold the most recent row between pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_valid_q <= 1'b0;
            row_idx_q   <= 4'd0;
            row_data_q  <= 10'd0;
        end else begin
            row_valid_q <= capture_row;
            if (capture_row) begin
                row_idx_q  <= idx;
                row_data_q <= bus.r;
            end
        end
    end

    // Capture table. A start does not clear it, because every scan
    // overwrites all 16 entries anyway. Only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                mem[i] <= 10'd0;
            end
        end else if (capture_row) begin
            mem[idx] <= bus.r;
        end
    end

    // Registered read port, active in every state. A read and a capture to
    // the same entry on the same edge return the old contents. The new value
    // shows up one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= 10'd0;
        end else begin
            rd_data_q <= mem[bus.rd_addr];
        end
    end

    assign {bus.w, bus.x, bus.y, bus.z} = idx;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.ones_count = ones_q;
    assign bus.row_valid  = row_valid_q;
    assign bus.row_idx    = row_idx_q;
    assign bus.row_data   = row_data_q;
    assign bus.rd_data    = rd_data_q;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// tb_truth_table_sequencer
//
// Purpose: self-checking bench for truth_table_sequencer. Two instances are
// built, one with SETTLE = 3 (index 0) and one with SETTLE = 1 (index 1).
// Both are fed by a table-based breadboard model. Expected outputs come from
// the scan timing rules: after edge t of a scan, code = t/(SETTLE+1), capped
// at 15, and a row lands whenever t is a multiple of SETTLE+1.
module tb_truth_table_sequencer;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    truth_table_sequencer_if bus_s3 ();
    truth_table_sequencer_if bus_s1 ();

    truth_table_sequencer #(.SETTLE(3)) dut_s3 (.clk(clk), .rst_n(rst_n), .bus(bus_s3));
    truth_table_sequencer #(.SETTLE(1)) dut_s1 (.clk(clk), .rst_n(rst_n), .bus(bus_s1));

    // Breadboard model: response looked up by code, with an optional
    // per-instance override used to plant a known value.
    logic [9:0] bb_table [16];
    logic [1:0] force_en;
    logic [9:0] force_val;

    assign bus_s3.r = force_en[0] ? force_val : bb_table[{bus_s3.w, bus_s3.x, bus_s3.y, bus_s3.z}];
    assign bus_s1.r = force_en[1] ? force_val : bb_table[{bus_s1.w, bus_s1.x, bus_s1.y, bus_s1.z}];

    typedef struct {
        logic [3:0] code;
        logic [9:0] resp;
    } bb_vec_t;

    typedef struct {
        logic [3:0] addr;
        logic [9:0] expected;
    } rd_vec_t;

    typedef struct packed {
        logic       busy;
        logic       row_valid;
        logic       done;
        logic [3:0] code;
        logic [3:0] row_idx;
        logic [9:0] row_data;
        logic [7:0] ones;
        logic [9:0] rd_data;
    } obs_t;

    bb_vec_t    bb_vecs [16];
    rd_vec_t    rd_vecs [6];
    logic [9:0] exp_mem [2][16];

    int checks = 0;
    int passes = 0;

    function automatic int settle_of(input int d);
        return (d == 0) ? 3 : 1;
    endfunction

    function automatic obs_t sample(input int d);
        obs_t o;
        if (d == 0) begin
            o.busy      = bus_s3.busy;
            o.row_valid = bus_s3.row_valid;
            o.done      = bus_s3.done;
            o.code      = {bus_s3.w, bus_s3.x, bus_s3.y, bus_s3.z};
            o.row_idx   = bus_s3.row_idx;
            o.row_data  = bus_s3.row_data;
            o.ones      = bus_s3.ones_count;
            o.rd_data   = bus_s3.rd_data;
        end else begin
            o.busy      = bus_s1.busy;
            o.row_valid = bus_s1.row_valid;
            o.done      = bus_s1.done;
            o.code      = {bus_s1.w, bus_s1.x, bus_s1.y, bus_s1.z};
            o.row_idx   = bus_s1.row_idx;
            o.row_data  = bus_s1.row_data;
            o.ones      = bus_s1.ones_count;
            o.rd_data   = bus_s1.rd_data;
        end
        return o;
    endfunction

    task automatic apply_stimulus(input int d, input logic start_v, input logic [3:0] addr_v);
        if (d == 0) begin
            bus_s3.start   = start_v;
            bus_s3.rd_addr = addr_v;
        end else begin
            bus_s1.start   = start_v;
            bus_s1.rd_addr = addr_v;
        end
    endtask

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end else begin
            passes++;
        end
    endtask

    task automatic check_all_zero(input int d, input string tag);
        obs_t o;
        o = sample(d);
        check_output($sformatf("%s_busy_d%0d", tag, d),      32'(o.busy),      32'd0);
        check_output($sformatf("%s_row_valid_d%0d", tag, d), 32'(o.row_valid), 32'd0);
        check_output($sformatf("%s_done_d%0d", tag, d),      32'(o.done),      32'd0);
        check_output($sformatf("%s_code_d%0d", tag, d),      32'(o.code),      32'd0);
        check_output($sformatf("%s_row_idx_d%0d", tag, d),   32'(o.row_idx),   32'd0);
        check_output($sformatf("%s_row_data_d%0d", tag, d),  32'(o.row_data),  32'd0);
        check_output($sformatf("%s_ones_d%0d", tag, d),      32'(o.ones),      32'd0);
        check_output($sformatf("%s_rd_data_d%0d", tag, d),   32'(o.rd_data),   32'd0);
    endtask

    // Put the address on the port, wait one edge and check the registered data.
    task automatic read_check(input int d, input logic [3:0] addr, input logic [9:0] expected);
        obs_t o;
        apply_stimulus(d, 1'b0, addr);
        @(posedge clk);
        #1;
        o = sample(d);
        check_output($sformatf("rd_data_d%0d_a%0d", d, addr), 32'(o.rd_data), 32'(expected));
    endtask

    // Start a scan (start is high for the accepting edge) and check every
    // output on every cycle from E0 to the done edge. The call begins and
    // ends 1 time unit after a rising edge.
    task automatic run_scan(input int d, input bit hold_start);
        int         period;
        int         last_t;
        int         rows_done;
        int         exp_code;
        logic [7:0] exp_ones;
        logic [9:0] snap [16];
        obs_t       o;
        period = settle_of(d) + 1;
        last_t = 16 * period;
        for (int j = 0; j < 16; j++) begin
            snap[j] = bb_table[j];
        end
        apply_stimulus(d, 1'b1, 4'd0);
        @(posedge clk);
        #1;
        if (!hold_start) begin
            apply_stimulus(d, 1'b0, 4'd0);
        end
        for (int t = 0; t <= last_t; t++) begin
            if (t > 0) begin
                @(posedge clk);
                #1;
            end
            o = sample(d);
            rows_done = t / period;
            exp_code  = (rows_done > 15) ? 15 : rows_done;
            exp_ones  = 8'd0;
            for (int j = 0; j < rows_done; j++) begin
                exp_ones = exp_ones + 8'($countones(snap[j]));
            end
            check_output($sformatf("busy_d%0d_t%0d", d, t),      32'(o.busy),      32'(t < last_t));
            check_output($sformatf("code_d%0d_t%0d", d, t),      32'(o.code),      32'(exp_code));
            check_output($sformatf("row_valid_d%0d_t%0d", d, t), 32'(o.row_valid), 32'(t > 0 && t % period == 0));
            check_output($sformatf("done_d%0d_t%0d", d, t),      32'(o.done),      32'(t == last_t));
            check_output($sformatf("ones_d%0d_t%0d", d, t),      32'(o.ones),      32'(exp_ones));
            if (t > 0 && t % period == 0) begin
                check_output($sformatf("row_idx_d%0d_t%0d", d, t),  32'(o.row_idx),  32'(rows_done - 1));
                check_output($sformatf("row_data_d%0d_t%0d", d, t), 32'(o.row_data), 32'(snap[rows_done - 1]));
            end
        end
        for (int j = 0; j < 16; j++) begin
            exp_mem[d][j] = snap[j];
        end
    endtask

    initial begin
        obs_t       o;
        logic [7:0] exp_ones;

        // Default breadboard response: row 0 = 0x020, row 15 = 0x11F, 64 ones total.
        bb_vecs[0]  = '{4'd0,  10'h020};
        bb_vecs[1]  = '{4'd1,  10'h0F0};
        bb_vecs[2]  = '{4'd2,  10'h10F};
        bb_vecs[3]  = '{4'd3,  10'h033};
        bb_vecs[4]  = '{4'd4,  10'h055};
        bb_vecs[5]  = '{4'd5,  10'h0AA};
        bb_vecs[6]  = '{4'd6,  10'h0CC};
        bb_vecs[7]  = '{4'd7,  10'h30C};
        bb_vecs[8]  = '{4'd8,  10'h00F};
        bb_vecs[9]  = '{4'd9,  10'h2A1};
        bb_vecs[10] = '{4'd10, 10'h14A};
        bb_vecs[11] = '{4'd11, 10'h3C0};
        bb_vecs[12] = '{4'd12, 10'h099};
        bb_vecs[13] = '{4'd13, 10'h231};
        bb_vecs[14] = '{4'd14, 10'h1E0};
        bb_vecs[15] = '{4'd15, 10'h11F};

        rd_vecs[0] = '{4'd0,  10'h020};
        rd_vecs[1] = '{4'd15, 10'h11F};
        rd_vecs[2] = '{4'd5,  10'h0AA};
        rd_vecs[3] = '{4'd9,  10'h2A1};
        rd_vecs[4] = '{4'd7,  10'h30C};
        rd_vecs[5] = '{4'd2,  10'h10F};

        for (int i = 0; i < 16; i++) begin
            bb_table[bb_vecs[i].code] = bb_vecs[i].resp;
        end
        for (int d = 0; d < 2; d++) begin
            for (int j = 0; j < 16; j++) begin
                exp_mem[d][j] = 10'd0;
            end
        end
        force_en  = 2'b00;
        force_val = 10'h3FF;
        apply_stimulus(0, 1'b0, 4'd0);
        apply_stimulus(1, 1'b0, 4'd0);

        // Reset state
        rst_n = 1'b1;
        #2;
        rst_n = 1'b0;
        #2;
        check_all_zero(0, "reset");
        check_all_zero(1, "reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single scan, SETTLE = 3
        $display("[TB] single scan, SETTLE=3");
        run_scan(0, 1'b0);
        o = sample(0);
        check_output("scan1_ones_total", 32'(o.ones), 32'd64);

        // Table readout
        $display("[TB] table readout");
        for (int i = 0; i < 6; i++) begin
            read_check(0, rd_vecs[i].addr, rd_vecs[i].expected);
        end

        // start held high across a whole scan, then straight into a second one
        $display("[TB] start held high");
        run_scan(0, 1'b1);
        run_scan(0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            o = sample(0);
            check_output($sformatf("idle_after_hold_busy_%0d", i), 32'(o.busy), 32'd0);
        end

        // SETTLE = 1
        $display("[TB] single scan, SETTLE=1");
        run_scan(1, 1'b0);
        o = sample(1);
        check_output("s1_ones_total", 32'(o.ones), 32'd64);
        for (int i = 0; i < 6; i++) begin
            read_check(1, rd_vecs[i].addr, rd_vecs[i].expected);
        end

        // Read collision: address 5 during the row-5 capture, response forced to 0x3FF
        $display("[TB] read collision");
        apply_stimulus(0, 1'b1, 4'd5);
        @(posedge clk);
        #1;
        apply_stimulus(0, 1'b0, 4'd5);
        repeat (23) @(posedge clk);
        #1;
        force_en[0] = 1'b1;
        @(posedge clk);
        #1;
        o = sample(0);
        check_output("collide_rd_old",   32'(o.rd_data),  32'(exp_mem[0][5]));
        check_output("collide_row_data", 32'(o.row_data), 32'h3FF);
        check_output("collide_row_idx",  32'(o.row_idx),  32'd5);
        force_en[0] = 1'b0;
        @(posedge clk);
        #1;
        o = sample(0);
        check_output("collide_rd_new", 32'(o.rd_data), 32'h3FF);
        repeat (39) @(posedge clk);
        #1;
        exp_mem[0][5] = 10'h3FF;
        exp_ones = 8'd0;
        for (int j = 0; j < 16; j++) begin
            exp_ones = exp_ones + 8'($countones(exp_mem[0][j]));
        end
        o = sample(0);
        check_output("collide_done", 32'(o.done), 32'd1);
        check_output("collide_ones", 32'(o.ones), 32'(exp_ones));

        // Asynchronous reset in the middle of row 7's wait
        $display("[TB] reset mid-scan");
        apply_stimulus(0, 1'b1, 4'd5);
        @(posedge clk);
        #1;
        apply_stimulus(0, 1'b0, 4'd5);
        repeat (29) @(posedge clk);
        #3;
        o = sample(0);
        check_output("pre_reset_code", 32'(o.code), 32'd7);
        rst_n = 1'b0;
        #1;
        check_all_zero(0, "async_reset");
        check_all_zero(1, "async_reset");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int d = 0; d < 2; d++) begin
            for (int j = 0; j < 16; j++) begin
                exp_mem[d][j] = 10'd0;
            end
        end
        for (int i = 0; i < 80; i++) begin
            @(posedge clk);
            #1;
            o = sample(0);
            check_output($sformatf("post_reset_done_%0d", i), 32'(o.done), 32'd0);
            check_output($sformatf("post_reset_busy_%0d", i), 32'(o.busy), 32'd0);
        end
        read_check(0, 4'd3, 10'd0);

        // Random breadboard contents on both instances
        $display("[TB] randomized scans");
        for (int iter = 0; iter < 6; iter++) begin
            int d;
            d = iter % 2;
            for (int j = 0; j < 16; j++) begin
                bb_table[j] = 10'($urandom_range(0, 1023));
            end
            run_scan(d, 1'b0);
            for (int k = 0; k < 4; k++) begin
                logic [3:0] a;
                a = 4'($urandom_range(0, 15));
                read_check(d, a, exp_mem[d][a]);
            end
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
